// File: rtl/cmd_pkg.sv
// cmd_pkg: shared /CMD record constants and saver state encoding
package cmd_pkg;
    typedef enum logic [3:0] {
        IDLE, REC_TYPE, REC_LEN, REC_ALO, REC_AHI, RD_REQ, RD_WAIT, DATA_OUT,
        XF_TYPE, XF_LEN, XF_LO, XF_HI, FIN
    } state_t;
    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_XFER = 8'h02;
    localparam logic [7:0] XFER_LEN = 8'h02;
endpackage

// File: rtl/cmd_saver.sv
// cmd_saver: streams a RAM range out as TRS-80 /CMD load records plus an optional transfer record
//   clk_sys, reset                  : clock, async active-high reset
//   start, start_addr/end_addr/exec_addr : save request and its range and entry point
//   mem_addr, mem_rd, mem_data      : RAM read port, data one cycle after mem_rd
//   out_data, out_valid, out_ready  : byte stream with valid/ready handshake
//   busy, done, error               : status; done/error are one-cycle pulses
module cmd_saver
    import cmd_pkg::*;
#(
    parameter int MAX_BLOCK = 256,
    parameter bit EMIT_XFER = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] end_addr,
    input  logic [15:0] exec_addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);
    state_t      state_q;
    logic [15:0] addr_q, exec_q;
    logic [16:0] rem_q, rem_d;
    logic [8:0]  blk_q, blk_d;
    logic [7:0]  data_q;
    logic        valid_q, rd_q, busy_q, done_q, error_q;
    logic        xfer;
    assign xfer  = valid_q & out_ready;
    assign rem_d = {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;
    assign blk_d = (rem_q >= 17'(MAX_BLOCK)) ? 9'(MAX_BLOCK) : rem_q[8:0];
    assign mem_addr  = addr_q;
    assign mem_rd    = rd_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            exec_q  <= '0;
            rem_q   <= '0;
            blk_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rd_q    <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (end_addr < start_addr) error_q <= 1'b1;
                    else begin
                        busy_q  <= 1'b1;
                        addr_q  <= start_addr;
                        exec_q  <= exec_addr;
                        rem_q   <= rem_d;
                        data_q  <= CMD_LOAD;
                        valid_q <= 1'b1;
                        state_q <= REC_TYPE;
                    end
                end
                REC_TYPE: if (xfer) begin
                    blk_q   <= blk_d;
                    data_q  <= 8'(blk_d + 9'd2);
                    state_q <= REC_LEN;
                end
                REC_LEN: if (xfer) begin
                    data_q  <= addr_q[7:0];
                    state_q <= REC_ALO;
                end
                REC_ALO: if (xfer) begin
                    data_q  <= addr_q[15:8];
                    state_q <= REC_AHI;
                end
                REC_AHI: if (xfer) begin
                    valid_q <= 1'b0;
                    rd_q    <= 1'b1;
                    state_q <= RD_REQ;
                end
                RD_REQ: state_q <= RD_WAIT;
                RD_WAIT: begin
                    data_q  <= mem_data;
                    valid_q <= 1'b1;
                    state_q <= DATA_OUT;
                end
                DATA_OUT: if (xfer) begin
                    rem_q <= rem_q - 17'd1;
                    blk_q <= blk_q - 9'd1;
                    // holding the address on the final byte keeps 0xFFFF from wrapping
                    if (rem_q > 17'd1) addr_q <= addr_q + 16'd1;
                    if (blk_q > 9'd1) begin
                        valid_q <= 1'b0;
                        rd_q    <= 1'b1;
                        state_q <= RD_REQ;
                    end else if (rem_q > 17'd1) begin
                        data_q  <= CMD_LOAD;
                        state_q <= REC_TYPE;
                    end else if (EMIT_XFER) begin
                        data_q  <= CMD_XFER;
                        state_q <= XF_TYPE;
                    end else begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                XF_TYPE: if (xfer) begin
                    data_q  <= XFER_LEN;
                    state_q <= XF_LEN;
                end
                XF_LEN: if (xfer) begin
                    data_q  <= exec_q[7:0];
                    state_q <= XF_LO;
                end
                XF_LO: if (xfer) begin
                    data_q  <= exec_q[15:8];
                    state_q <= XF_HI;
                end
                XF_HI: if (xfer) begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
